// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity,
    StStop
  } frame_state_e;

  localparam logic [7:0] PrefixExt   = 8'hE0;
  localparam logic [7:0] PrefixRel   = 8'hF0;
  localparam logic [7:0] PrefixPause = 8'hE1;

  // Bytes following E1 that belong to the Pause sequence and are dropped.
  localparam logic [2:0] PauseSkipLen = 3'd7;

  // Keyboard status/ack codes that never form key events.
  function automatic logic is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame deserialiser with timeout abort.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 60000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  logic [1:0]      clk_sync_q;
  logic [1:0]      data_sync_q;
  logic            clk_filt_q;
  logic            clk_filt_prev_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic            fall;
  logic            data_s;

  frame_state_e    state_q;
  logic [2:0]      bit_cnt_q;
  logic            parity_q;
  logic [TmoW-1:0] tmo_cnt_q;

  assign data_s = data_sync_q[1];
  assign fall   = clk_filt_prev_q & ~clk_filt_q;

  // Two-flop synchronisers; lines idle high.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  // Glitch filter: level follows the sample only after FILTER_LEN disagreeing samples in a row.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt_q      <= 1'b1;
      clk_filt_prev_q <= 1'b1;
      filt_cnt_q      <= '0;
    end else begin
      clk_filt_prev_q <= clk_filt_q;
      if (clk_sync_q[1] == clk_filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
        clk_filt_q <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  // Frame FSM with timeout; byte_valid and frame_err are registered single-cycle pulses.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      parity_q   <= 1'b0;
      rx_byte    <= '0;
      tmo_cnt_q  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        // An edge always wins over a coincident timeout.
        tmo_cnt_q <= '0;
        unique case (state_q)
          StIdle: begin
            if (!data_s) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            rx_byte   <= {data_s, rx_byte[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= StParity;
            end
          end
          StParity: begin
            parity_q <= data_s;
            state_q  <= StStop;
          end
          StStop: begin
            if (data_s && ((^rx_byte) ^ parity_q)) begin
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end else if (state_q == StIdle) begin
        tmo_cnt_q <= '0;
      end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
        tmo_cnt_q <= '0;
        state_q   <= StIdle;
        frame_err <= 1'b1;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: folds E0/F0/E1 prefixes into toggle-strobed key events.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 60000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       ext_q;
  logic       rel_q;
  logic [2:0] skip_q;

  ps2_frame_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_frame_rx (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  // Prefix assembler: accumulate flags, drop Pause tail and status codes, emit on real keys.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_key <= '0;
      ext_q   <= 1'b0;
      rel_q   <= 1'b0;
      skip_q  <= '0;
    end else if (frame_err) begin
      ext_q  <= 1'b0;
      rel_q  <= 1'b0;
      skip_q <= '0;
    end else if (byte_valid) begin
      if (skip_q != '0) begin
        skip_q <= skip_q - 1'b1;
      end else if (rx_byte == PrefixExt) begin
        ext_q <= 1'b1;
      end else if (rx_byte == PrefixRel) begin
        rel_q <= 1'b1;
      end else if (rx_byte == PrefixPause) begin
        skip_q <= PauseSkipLen;
      end else if (!is_discard(rx_byte)) begin
        ps2_key <= {~ps2_key[10], ~rel_q, ext_q, rx_byte};
        ext_q   <= 1'b0;
        rel_q   <= 1'b0;
      end
    end
  end

  // Saturating error counter.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt <= '0;
    end else if (frame_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed frames, monitor compares key events and errors.
module tb_ps2_scancode_rx;

  localparam int unsigned FilterLen = 8;
  localparam int unsigned Timeout   = 2000;

  logic        clk_sys;
  logic        reset_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic [7:0]  err_cnt;

  int n_checks;
  int n_fail;

  logic [10:0] exp_key_q[$];
  logic [7:0]  exp_err_q[$];

  logic        mon_en;
  logic [10:0] last_key;
  logic        err_pending;
  logic [7:0]  err_exp;
  logic [10:0] key_exp;

  ps2_scancode_rx #(
    .FILTER_LEN(FilterLen),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err),
    .err_cnt  (err_cnt)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  // One PS/2 bit: data set while clock high, clock low long enough to pass the filter.
  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cycles(20);
    ps2_clk = 1'b0;
    wait_cycles(40);
    ps2_clk = 1'b1;
    wait_cycles(20);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_parity, input logic bad_stop);
    logic par;
    par = ~(^b) ^ bad_parity;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_cycles(30);
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  // Monitor: any change of ps2_key is an event to match; any frame_err pulse is an error to match.
  always @(negedge clk_sys) begin
    if (mon_en) begin
      if (err_pending) begin
        check("err_cnt_after_err", {24'd0, err_cnt}, {24'd0, err_exp});
        check("frame_err_one_cycle", {31'd0, frame_err}, 32'd0);
        err_pending = 1'b0;
      end else if (frame_err) begin
        if (exp_err_q.size() == 0) begin
          check("unexpected_frame_err", {24'd0, err_cnt}, 32'hFFFF_FFFF);
        end else begin
          err_exp     = exp_err_q.pop_front();
          err_pending = 1'b1;
        end
      end
      if (ps2_key !== last_key) begin
        if (exp_key_q.size() == 0) begin
          check("unexpected_key_event", {21'd0, ps2_key}, {21'd0, last_key});
        end else begin
          key_exp = exp_key_q.pop_front();
          check("ps2_key_event", {21'd0, ps2_key}, {21'd0, key_exp});
        end
        last_key = ps2_key;
      end
    end
  end

  // Hard bound on run time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    mon_en      = 1'b0;
    err_pending = 1'b0;
    last_key    = '0;
    ps2_clk     = 1'b1;
    ps2_data    = 1'b1;
    reset_n     = 1'b0;
    wait_cycles(5);
    @(negedge clk_sys);
    check("reset_ps2_key", {21'd0, ps2_key}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
    reset_n = 1'b1;
    wait_cycles(5);
    mon_en = 1'b1;

    // Plain make code: toggle 1, press, no ext.
    exp_key_q.push_back(11'h61C);
    send_ok(8'h1C);

    // Extended release: toggle back to 0.
    exp_key_q.push_back(11'h175);
    send_ok(8'hE0);
    send_ok(8'hF0);
    send_ok(8'h75);

    // Ack code discarded, then a press.
    exp_key_q.push_back(11'h61C);
    send_ok(8'hFA);
    send_ok(8'h1C);

    // Parity error, key unchanged.
    exp_err_q.push_back(8'd1);
    send_frame(8'h1C, 1'b1, 1'b0);
    check("key_held_after_parity_err", {21'd0, ps2_key}, 32'h61C);

    // Extended press from a fresh E0.
    exp_key_q.push_back(11'h374);
    send_ok(8'hE0);
    send_ok(8'h74);

    // Stop-bit error after E0 clears the ext flag.
    exp_err_q.push_back(8'd2);
    exp_key_q.push_back(11'h674);
    send_ok(8'hE0);
    send_frame(8'h33, 1'b0, 1'b1);
    send_ok(8'h74);

    // Pause sequence dropped, then a normal key.
    exp_key_q.push_back(11'h229);
    send_ok(8'hE1);
    send_ok(8'h14);
    send_ok(8'h77);
    send_ok(8'hE1);
    send_ok(8'hF0);
    send_ok(8'h14);
    send_ok(8'hF0);
    send_ok(8'h77);
    send_ok(8'h29);

    // Start bit plus three data bits, then silence past the timeout.
    exp_err_q.push_back(8'd3);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data = 1'b1;
    wait_cycles(Timeout + 500);
    exp_key_q.push_back(11'h65A);
    send_ok(8'h5A);

    // Short glitches on the clock while idle are ignored.
    for (int g = 0; g < 6; g++) begin
      ps2_clk = 1'b0;
      wait_cycles(2);
      ps2_clk = 1'b1;
      wait_cycles(12);
    end
    wait_cycles(50);
    check("err_cnt_after_glitches", {24'd0, err_cnt}, 32'd3);
    exp_key_q.push_back(11'h21C);
    send_ok(8'h1C);

    wait_cycles(50);
    check("key_queue_drained", exp_key_q.size(), 32'd0);
    check("err_queue_drained", exp_err_q.size(), 32'd0);
    check("final_ps2_key", {21'd0, ps2_key}, 32'h21C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
